ex_stage: RTL and testbench

Execute stage of the veriRISCV in-order pipeline, sitting between ID and MEM. It performs all single-cycle integer ALU operations and the low-word multiply. It also runs a multi-cycle restoring divider for DIV/DIVU/REM/REMU, stalling upstream while the divider is busy. Its registered outputs are the EX/MEM pipeline register consumed directly by MEM.

---
 rtl/ex_stage_if.sv | 30 +++
 rtl/ex_stage.sv | 158 +++++++++++++++
 tb/tb_ex_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID -> EX -> MEM signal bundle for the execute stage.
// The master side drives the ID/EX inputs and flush; the slave side is ex_stage.
interface ex_stage_if #(parameter int XLEN = 32);
    logic            id_reg_wen;
    logic [4:0]      id_reg_waddr;
    logic [XLEN-1:0] id_op1;
    logic [XLEN-1:0] id_op2;
    logic [3:0]      id_alu_op;
    logic            id_div_req;
    logic [1:0]      id_div_op;
    logic            id_ill_instr;
    logic            ex_flush;
    logic            ex_stall;
    logic            ex_reg_wen;
    logic [4:0]      ex_reg_waddr;
    logic [XLEN-1:0] ex_alu_out;
    logic            ex_ill_instr;

    modport master (
        output id_reg_wen, id_reg_waddr, id_op1, id_op2, id_alu_op,
               id_div_req, id_div_op, id_ill_instr, ex_flush,
        input  ex_stall, ex_reg_wen, ex_reg_waddr, ex_alu_out, ex_ill_instr
    );

    modport slave (
        input  id_reg_wen, id_reg_waddr, id_op1, id_op2, id_alu_op,
               id_div_req, id_div_op, id_ill_instr, ex_flush,
        output ex_stall, ex_reg_wen, ex_reg_waddr, ex_alu_out, ex_ill_instr
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU and low-word multiply, plus a
// restoring divider (one quotient bit per cycle) that stalls upstream.
//
// state | meaning
// IDLE  | no divide in flight; ALU results pass straight through
// BUSY  | shifting out quotient bits, counter XLEN-1 down to 0
// DONE  | divider result valid; captured into EX/MEM this cycle
module ex_stage #(parameter int XLEN = 32) (
    input logic      clk,
    input logic      rst,
    ex_stage_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo, rem, dvsr, spec_res;
    logic            neg_q, neg_r, is_rem, special;

    logic [XLEN-1:0] alu_res, div_res;
    logic [CW-1:0]   shamt;
    logic            div_start, sgn, a_neg, b_neg, spec_start;
    logic [XLEN-1:0] mag_a, mag_b, spec_val;
    logic [XLEN:0]   r_shift;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] min_neg;

    assign min_neg   = {1'b1, {(XLEN-1){1'b0}}};
    assign shamt     = bus.id_op2[CW-1:0];
    assign div_start = (state == IDLE) & bus.id_div_req & ~bus.id_ill_instr & ~bus.ex_flush;
    // a flushed BUSY cycle ends at this edge, so it no longer holds upstream
    assign bus.ex_stall = div_start | ((state == BUSY) & ~bus.ex_flush);

    // single-cycle ALU result
    always_comb begin
        alu_res = '0;
        case (bus.id_alu_op)
            4'd0:  alu_res = bus.id_op1 + bus.id_op2;
            4'd1:  alu_res = bus.id_op1 - bus.id_op2;
            4'd2:  alu_res = bus.id_op1 << shamt;
            4'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.id_op1) < $signed(bus.id_op2)};
            4'd4:  alu_res = {{(XLEN-1){1'b0}}, bus.id_op1 < bus.id_op2};
            4'd5:  alu_res = bus.id_op1 ^ bus.id_op2;
            4'd6:  alu_res = bus.id_op1 >> shamt;
            4'd7:  alu_res = $signed(bus.id_op1) >>> shamt;
            4'd8:  alu_res = bus.id_op1 | bus.id_op2;
            4'd9:  alu_res = bus.id_op1 & bus.id_op2;
            4'd10: alu_res = bus.id_op2;
            4'd11: alu_res = bus.id_op1 * bus.id_op2;
            default: alu_res = '0;
        endcase
    end

    // operand magnitudes and special-case detection at divider start
    always_comb begin
        sgn        = ~bus.id_div_op[0];
        a_neg      = sgn & bus.id_op1[XLEN-1];
        b_neg      = sgn & bus.id_op2[XLEN-1];
        mag_a      = a_neg ? -bus.id_op1 : bus.id_op1;
        mag_b      = b_neg ? -bus.id_op2 : bus.id_op2;
        spec_start = 1'b0;
        spec_val   = '0;
        if (bus.id_op2 == '0) begin
            spec_start = 1'b1;
            spec_val   = bus.id_div_op[1] ? bus.id_op1 : '1;
        end else if (sgn && bus.id_op1 == min_neg && bus.id_op2 == '1) begin
            spec_start = 1'b1;
            spec_val   = bus.id_div_op[1] ? '0 : min_neg;
        end
    end

    // one restoring step and final sign fix-up
    always_comb begin
        r_shift = {rem, quo[XLEN-1]};
        diff    = {1'b0, r_shift} - {2'b00, dvsr};
        if (special)
            div_res = spec_res;
        else if (is_rem)
            div_res = neg_r ? -rem : rem;
        else
            div_res = neg_q ? -quo : quo;
    end

    // divider state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // divider next-state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (div_start) state_next = spec_start ? DONE : BUSY;
            BUSY: if (cnt == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.ex_flush)
            state_next = IDLE;
    end

    // divider datapath: load on start, shift/subtract while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            spec_res <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem   <= 1'b0;
            special  <= 1'b0;
        end else if (div_start) begin
            cnt      <= CW'(XLEN-1);
            quo      <= mag_a;
            rem      <= '0;
            dvsr     <= mag_b;
            spec_res <= spec_val;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            is_rem   <= bus.id_div_op[1];
            special  <= spec_start;
        end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
            if (!diff[XLEN+1]) begin
                rem <= diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= r_shift[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

    // EX/MEM pipeline register; flush and stall both insert a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_reg_wen   <= 1'b0;
            bus.ex_reg_waddr <= '0;
            bus.ex_alu_out   <= '0;
            bus.ex_ill_instr <= 1'b0;
        end else if (bus.ex_flush || bus.ex_stall) begin
            bus.ex_reg_wen   <= 1'b0;
            bus.ex_ill_instr <= 1'b0;
        end else begin
            bus.ex_reg_wen   <= bus.id_reg_wen & ~bus.id_ill_instr;
            bus.ex_reg_waddr <= bus.id_reg_waddr;
            bus.ex_ill_instr <= bus.id_ill_instr;
            bus.ex_alu_out   <= (state == DONE) ? div_res : alu_res;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is presented and compared when it leaves the stage.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if #(.XLEN(32)) bus ();
    ex_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic        ill;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[4:0];
            4'd7:  return $signed(a) >>> b[4:0];
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            4'd11: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] div_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0: return $signed(a) / $signed(b);
            2'd1: return a / b;
            2'd2: return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // present one instruction (called just after a negedge), follow it through
    // any stall, then compare against the scoreboard head
    task automatic issue(input string tag, input logic [3:0] alu_op, input logic div_req,
                         input logic [1:0] div_op, input logic ill, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] waddr,
                         input logic [31:0] exp_res, input int exp_stall);
        exp_t e;
        int   stalls;
        logic st;
        bus.id_reg_wen   = 1'b1;
        bus.id_reg_waddr = waddr;
        bus.id_op1       = a;
        bus.id_op2       = b;
        bus.id_alu_op    = alu_op;
        bus.id_div_req   = div_req;
        bus.id_div_op    = div_op;
        bus.id_ill_instr = ill;
        e.wen = ~ill; e.waddr = waddr; e.ill = ill; e.res = exp_res;
        sb.push_back(e);
        stalls = 0;
        st     = 1'b1;
        for (int i = 0; i < 100 && st; i++) begin
            #1 st = bus.ex_stall;
            @(posedge clk);
            #1;
            if (st) begin
                stalls++;
                check({tag, "_bubble_wen"}, {31'b0, bus.ex_reg_wen}, 32'd0);
                @(negedge clk);
            end
        end
        check({tag, "_stall_cycles"}, stalls, exp_stall);
        e = sb.pop_front();
        check({tag, "_result"}, bus.ex_alu_out, e.res);
        check({tag, "_wen"},    {31'b0, bus.ex_reg_wen}, {31'b0, e.wen});
        check({tag, "_waddr"},  {27'b0, bus.ex_reg_waddr}, {27'b0, e.waddr});
        check({tag, "_ill"},    {31'b0, bus.ex_ill_instr}, {31'b0, e.ill});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        rst = 1'b1;
        bus.id_reg_wen = 0; bus.id_reg_waddr = 0; bus.id_op1 = 0; bus.id_op2 = 0;
        bus.id_alu_op = 0; bus.id_div_req = 0; bus.id_div_op = 0; bus.id_ill_instr = 0;
        bus.ex_flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wen",   {31'b0, bus.ex_reg_wen}, 32'd0);
        check("rst_waddr", {27'b0, bus.ex_reg_waddr}, 32'd0);
        check("rst_out",   bus.ex_alu_out, 32'd0);
        check("rst_ill",   {31'b0, bus.ex_ill_instr}, 32'd0);
        check("rst_stall", {31'b0, bus.ex_stall}, 32'd0);
        rst = 1'b0;

        issue("add_wrap", 4'd0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1, 5'd1, 32'h0, 0);
        issue("sra",      4'd7, 0, 0, 0, 32'h8000_0000, 32'd4, 5'd2, 32'hF800_0000, 0);
        issue("slt",      4'd3, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1, 0);
        issue("sltu",     4'd4, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'd0, 0);
        issue("srl",      4'd6, 0, 0, 0, 32'h8000_0000, 32'd4, 5'd5, 32'h0800_0000, 0);
        issue("sll",      4'd2, 0, 0, 0, 32'h0000_0003, 32'd33, 5'd6, 32'h0000_0006, 0);
        issue("mul",      4'd11, 0, 0, 0, 32'h0001_0001, 32'h0001_0003, 5'd7, 32'h0004_0003, 0);
        issue("op15_zero", 4'd15, 0, 0, 0, 32'h1234_5678, 32'h1, 5'd8, 32'd0, 0);
        for (int k = 0; k < 8; k++) begin
            ra = $urandom; rb = $urandom; rop = 4'($urandom_range(0, 11));
            issue("alu_rand", rop, 0, 0, 0, ra, rb, 5'(k + 9), alu_model(rop, ra, rb), 0);
        end

        issue("div_neg",   4'd0, 1, 2'd0, 0, -32'sd7, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
        issue("rem_neg",   4'd0, 1, 2'd2, 0, -32'sd7, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
        issue("divu_z",    4'd0, 1, 2'd1, 0, 32'd100, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
        issue("remu_z",    4'd0, 1, 2'd3, 0, 32'd100, 32'd0, 5'd13, 32'd100, 1);
        issue("div_ovf",   4'd0, 1, 2'd0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        issue("rem_ovf",   4'd0, 1, 2'd2, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);
        issue("divu_b2b",  4'd0, 1, 2'd1, 0, 32'hFFFF_FFF0, 32'd7, 5'd16, div_model(2'd1, 32'hFFFF_FFF0, 32'd7), 33);
        issue("remu_b2b",  4'd0, 1, 2'd3, 0, 32'hFFFF_FFF0, 32'd7, 5'd17, div_model(2'd3, 32'hFFFF_FFF0, 32'd7), 33);
        issue("div_mixed", 4'd0, 1, 2'd0, 0, 32'd1000, -32'sd33, 5'd18, div_model(2'd0, 32'd1000, -32'sd33), 33);
        issue("ill_div",   4'd0, 1, 2'd0, 1, 32'd5, 32'd6, 5'd19, 32'd11, 0);

        // flush ten cycles into a DIVU
        bus.id_reg_wen = 1; bus.id_reg_waddr = 5'd20; bus.id_op1 = 32'd1000; bus.id_op2 = 32'd3;
        bus.id_div_req = 1; bus.id_div_op = 2'd1; bus.id_ill_instr = 0;
        #1 check("flush_pre_stall", {31'b0, bus.ex_stall}, 32'd1);
        repeat (10) @(negedge clk);
        bus.ex_flush = 1'b1;
        #1 check("flush_stall", {31'b0, bus.ex_stall}, 32'd0);
        @(posedge clk);
        #1 check("flush_wen", {31'b0, bus.ex_reg_wen}, 32'd0);
        @(negedge clk);
        bus.ex_flush = 1'b0;
        issue("add_after_flush", 4'd0, 0, 0, 0, 32'd3, 32'd4, 5'd21, 32'd7, 0);

        // synchronous reset five cycles into a DIV
        bus.id_reg_wen = 1; bus.id_reg_waddr = 5'd22; bus.id_op1 = 32'd100; bus.id_op2 = 32'd7;
        bus.id_div_req = 1; bus.id_div_op = 2'd0;
        repeat (5) @(negedge clk);
        rst = 1'b1; bus.id_div_req = 0; bus.id_reg_wen = 0;
        @(posedge clk);
        #1;
        check("midrst_wen",   {31'b0, bus.ex_reg_wen}, 32'd0);
        check("midrst_waddr", {27'b0, bus.ex_reg_waddr}, 32'd0);
        check("midrst_out",   bus.ex_alu_out, 32'd0);
        check("midrst_ill",   {31'b0, bus.ex_ill_instr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_stall", {31'b0, bus.ex_stall}, 32'd0);
        @(negedge clk);
        issue("divu_after_rst", 4'd0, 1, 2'd1, 0, 32'd9, 32'd3, 5'd23, 32'd3, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
